// File: rtl/kulisch_pkg.sv
// Shared constants for the Kulisch accumulator and its FP16 normaliser.
// Both kulisch_acc_fp16 and kulisch_norm_fp16 import this package.
package kulisch_pkg;

    localparam int WWIDTH = 79;
    localparam int FWIDTH = 48;
    localparam int EWIDTH = 5;
    localparam int MWIDTH = 10;
    localparam int BIAS   = 15;
    localparam int PWIDTH = 7;

    localparam logic [15:0] FP16_POS_INF = 16'h7C00;
    localparam logic [15:0] FP16_NEG_INF = 16'hFC00;

endpackage

// File: rtl/kulisch_lzc.sv
// Combinational leading-one detector.
// Reports the bit index of the highest set bit, plus a flag for an all-zero input.
module kulisch_lzc #(
    parameter int WIDTH  = kulisch_pkg::WWIDTH,
    parameter int PWIDTH = kulisch_pkg::PWIDTH
) (
    input  logic [WIDTH-1:0]  data,
    output logic [PWIDTH-1:0] pos,
    output logic              zero
);

    // Scanning upward means the last hit is the highest set bit.
    always_comb begin
        pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                pos = PWIDTH'(i);
            end
        end
    end

    assign zero = ~|data;

endmodule

// File: rtl/kulisch_norm_fp16.sv
// Three-stage normaliser: converts a Kulisch fixed-point accumulator to FP16,
// rounding to nearest-even and saturating to infinity on overflow.
module kulisch_norm_fp16 #(
    parameter int WWIDTH = kulisch_pkg::WWIDTH,
    parameter int FWIDTH = kulisch_pkg::FWIDTH,
    parameter int EWIDTH = kulisch_pkg::EWIDTH,
    parameter int MWIDTH = kulisch_pkg::MWIDTH,
    parameter int BIAS   = kulisch_pkg::BIAS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [WWIDTH-1:0] i_acc,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [15:0]       o_fp_data,
    output logic              o_overflow,
    output logic              o_inexact
);

    import kulisch_pkg::*;

    localparam int XWIDTH = EWIDTH + 2;
    localparam logic [PWIDTH-1:0] PMIN    = PWIDTH'(FWIDTH - BIAS + 1);
    localparam logic [PWIDTH-1:0] EOFF    = PWIDTH'(FWIDTH - BIAS);
    localparam logic [PWIDTH-1:0] TOP     = PWIDTH'(WWIDTH - 1);
    localparam logic [XWIDTH-1:0] EXP_INF = XWIDTH'((1 << EWIDTH) - 1);

    logic advance;

    logic              s1_valid;
    logic              s1_sign;
    logic [WWIDTH-1:0] s1_mag;

    logic              s2_valid;
    logic              s2_sign;
    logic [WWIDTH-2:0] s2_mag;
    logic [PWIDTH-1:0] s2_pos;
    logic              s2_zero;

    logic [PWIDTH-1:0] lzc_pos;
    logic              lzc_zero;

    logic                     subnormal;
    logic [PWIDTH-1:0]        eff_pos;
    logic [PWIDTH-1:0]        shamt;
    logic [XWIDTH-1:0]        exp_pre;
    logic [WWIDTH-2:0]        norm;
    logic [MWIDTH-1:0]        mant;
    logic                     guard;
    logic                     sticky;
    logic                     round_up;
    logic [XWIDTH+MWIDTH-1:0] rounded;
    logic                     overflow;
    logic                     inexact;
    logic [15:0]              result;

    assign advance = !o_valid || i_ready;
    assign o_ready = advance;

    kulisch_lzc #(
        .WIDTH (WWIDTH),
        .PWIDTH(PWIDTH)
    ) u_lzc (
        .data(s1_mag),
        .pos (lzc_pos),
        .zero(lzc_zero)
    );

    // Valid bits and the visible output registers are the only reset state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            o_valid    <= 1'b0;
            o_fp_data  <= '0;
            o_overflow <= 1'b0;
            o_inexact  <= 1'b0;
        end else if (advance) begin
            s1_valid <= i_valid;
            s2_valid <= s1_valid;
            o_valid  <= s2_valid;
            if (s2_valid) begin
                o_fp_data  <= result;
                o_overflow <= overflow;
                o_inexact  <= inexact;
            end
        end
    end

    // The magnitude MSB is only set for -2^(W-1), where it is the leading one itself,
    // so S2 keeps just the bits that can sit below a leading one.
    always_ff @(posedge clk) begin
        if (advance) begin
            s1_sign <= i_acc[WWIDTH-1];
            s1_mag  <= i_acc[WWIDTH-1] ? (~i_acc + 1'b1) : i_acc;
            s2_sign <= s1_sign;
            s2_mag  <= s1_mag[WWIDTH-2:0];
            s2_pos  <= lzc_pos;
            s2_zero <= lzc_zero;
        end
    end

    // Subnormals reuse the normal path by pinning the leading-one position to the
    // smallest normal exponent, which aligns mag[FWIDTH-15] to the mantissa MSB.
    always_comb begin
        subnormal = s2_pos < PMIN;
        eff_pos   = subnormal ? PMIN : s2_pos;
        shamt     = TOP - eff_pos;
        exp_pre   = subnormal ? '0 : XWIDTH'(s2_pos - EOFF);
        norm      = s2_mag << shamt;
        mant      = norm[WWIDTH-2 -: MWIDTH];
        guard     = norm[WWIDTH-2-MWIDTH];
        sticky    = |norm[WWIDTH-3-MWIDTH:0];
        round_up  = guard & (sticky | mant[0]);
        rounded   = {exp_pre, mant} + (XWIDTH+MWIDTH)'(round_up);
        overflow  = rounded[XWIDTH+MWIDTH-1:MWIDTH] >= EXP_INF;
        inexact   = guard | sticky | overflow;
        result    = {s2_sign, rounded[EWIDTH+MWIDTH-1:0]};
        if (s2_zero) begin
            result   = '0;
            overflow = 1'b0;
            inexact  = 1'b0;
        end else if (overflow) begin
            result = s2_sign ? FP16_NEG_INF : FP16_POS_INF;
        end
    end

endmodule

// File: tb/tb_kulisch_norm_fp16.sv
// Scoreboard bench for kulisch_norm_fp16: the driver queues hand-computed results,
// and the monitor compares them against each output transfer.
module tb_kulisch_norm_fp16;

    import kulisch_pkg::*;

    localparam int W = WWIDTH;

    typedef struct {
        logic [15:0] data;
        logic        ovf;
        logic        inx;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    typedef struct {
        logic [W-1:0] acc;
        logic [15:0]  data;
        logic         ovf;
        logic         inx;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_valid = 1'b0;
    logic         i_ready = 1'b1;
    logic [W-1:0] i_acc = '0;
    logic         o_ready;
    logic         o_valid;
    logic [15:0]  o_fp_data;
    logic         o_overflow;
    logic         o_inexact;

    exp_t sb[$];
    vec_t dir[$];
    vec_t strm[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_in = 0;
    int   n_out = 0;

    kulisch_norm_fp16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_acc     (i_acc),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_fp_data (o_fp_data),
        .o_overflow(o_overflow),
        .o_inexact (o_inexact)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] neg(input logic [W-1:0] x);
        return W'(0) - x;
    endfunction

    task automatic check_output(input string name, input logic [17:0] actual, input logic [17:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual %h expected %h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input vec_t v, input int n_stall, input bit chk_lat);
        int  tries = 0;
        bit  done  = 1'b0;
        exp_t e;
        while (!done) begin
            @(negedge clk);
            i_valid = 1'b1;
            i_acc   = v.acc;
            i_ready = (tries < n_stall) ? 1'b0 : 1'b1;
            #1;
            if (tries < n_stall) begin
                check_output("stall_o_ready", 18'(o_ready), 18'(0));
            end
            if (o_ready) begin
                e.data    = v.data;
                e.ovf     = v.ovf;
                e.inx     = v.inx;
                e.acc_cyc = cyc;
                e.chk_lat = chk_lat;
                sb.push_back(e);
                n_in++;
                done = 1'b1;
            end else if (tries >= n_stall + 20) begin
                check_output("accept_timeout", 18'(0), 18'(1));
                done = 1'b1;
            end
            tries++;
        end
    endtask

    task automatic drain();
        int budget = 0;
        @(negedge clk);
        i_valid = 1'b0;
        i_ready = 1'b1;
        while (sb.size() != 0 && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        repeat (2) @(negedge clk);
        check_output("drain_empty", 18'(sb.size()), 18'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_o_valid"}, 18'(o_valid), 18'(0));
        check_output({tag, "_o_fp_data"}, 18'(o_fp_data), 18'(0));
        check_output({tag, "_o_overflow"}, 18'(o_overflow), 18'(0));
        check_output({tag, "_o_inexact"}, 18'(o_inexact), 18'(0));
        check_output({tag, "_o_ready"}, 18'(o_ready), 18'(1));
    endtask

    // Monitor: every transfer (o_valid && i_ready before the edge) consumes one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && o_valid && i_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output actual %h expected none", o_fp_data);
                end else begin
                    e = sb.pop_front();
                    check_output("result", {o_overflow, o_inexact, o_fp_data}, {e.ovf, e.inx, e.data});
                    if (e.chk_lat) begin
                        check_output("latency", 18'(cyc - e.acc_cyc), 18'(3));
                    end
                end
            end
        end
    end

    initial begin
        dir.push_back('{W'(1) << 48,                      16'h3C00, 1'b0, 1'b0});
        dir.push_back('{neg(W'(1) << 48),                 16'hBC00, 1'b0, 1'b0});
        dir.push_back('{W'(0),                            16'h0000, 1'b0, 1'b0});
        dir.push_back('{W'(1) << 24,                      16'h0001, 1'b0, 1'b0});
        dir.push_back('{W'(3) << 23,                      16'h0002, 1'b0, 1'b1});
        dir.push_back('{W'(1) << 23,                      16'h0000, 1'b0, 1'b1});
        dir.push_back('{(W'(10'h3FF) << 24) + (W'(1) << 23), 16'h0400, 1'b0, 1'b1});
        dir.push_back('{W'(65504) << 48,                  16'h7BFF, 1'b0, 1'b0});
        dir.push_back('{W'(65520) << 48,                  16'h7C00, 1'b1, 1'b1});
        dir.push_back('{W'(1) << 78,                      16'hFC00, 1'b1, 1'b1});
        dir.push_back('{W'(1) << 64,                      16'h7C00, 1'b1, 1'b1});
        dir.push_back('{neg(W'(1) << 24),                 16'h8001, 1'b0, 1'b0});
        dir.push_back('{W'(3) << 47,                      16'h3E00, 1'b0, 1'b0});

        strm.push_back('{W'(1) << 48,      16'h3C00, 1'b0, 1'b0});
        strm.push_back('{W'(1) << 49,      16'h4000, 1'b0, 1'b0});
        strm.push_back('{W'(1) << 47,      16'h3800, 1'b0, 1'b0});
        strm.push_back('{W'(3) << 47,      16'h3E00, 1'b0, 1'b0});
        strm.push_back('{neg(W'(1) << 48), 16'hBC00, 1'b0, 1'b0});
        strm.push_back('{W'(1) << 24,      16'h0001, 1'b0, 1'b0});
        strm.push_back('{W'(65504) << 48,  16'h7BFF, 1'b0, 1'b0});
        strm.push_back('{W'(0),            16'h0000, 1'b0, 1'b0});

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        foreach (dir[k]) apply_stimulus(dir[k], 0, 1'b1);
        drain();

        // Back-to-back stream with the sink stalling for two consecutive cycles.
        foreach (strm[k]) apply_stimulus(strm[k], (k == 4) ? 2 : 0, 1'b0);
        drain();

        // Reset with three values in flight: none of them may ever emerge.
        for (int k = 0; k < 3; k++) apply_stimulus(dir[k], 0, 1'b0);
        @(negedge clk);
        #1;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        n_in    = n_in - sb.size();
        sb.delete();
        #1 check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        check_output("midrst_o_ready_held", 18'(o_ready), 18'(1));
        rst_n = 1'b1;
        apply_stimulus(dir[7], 0, 1'b1);
        apply_stimulus(dir[9], 0, 1'b1);
        drain();

        repeat (5) @(negedge clk);
        check_output("transfer_count", 18'(n_out), 18'(n_in));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kulisch_norm_fp16.md
KULISCH_NORM_FP16 -- requirements
Module: kulisch_norm_fp16

Interface
REQ-001 SHALL have parameter WWIDTH, default 79: accumulator width, two's complement.
REQ-002 SHALL have parameter FWIDTH, default 48: accumulator fraction bits (LSB weight 2^-48).
REQ-003 SHALL have parameters EWIDTH 5, MWIDTH 10, BIAS 15: FP16 output format.
REQ-004 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port i_valid  input  1: i_acc valid.
REQ-007 SHALL have port o_ready  output  1: block accepts i_acc this cycle.
REQ-008 SHALL have port i_acc  input  WWIDTH: Kulisch accumulator value from kulisch_acc_fp16.
REQ-009 SHALL have port o_valid  output  1: o_fp_data valid.
REQ-010 SHALL have port i_ready  input  1: downstream accepts output.
REQ-011 SHALL have port o_fp_data  output  16: rounded FP16 result.
REQ-012 SHALL have port o_overflow  output  1: result saturated to infinity.
REQ-013 SHALL have port o_inexact  output  1: rounding discarded nonzero bits.

Function
REQ-014 SHALL be a 3-stage pipeline: S1 sign/abs, S2 leading-one position, S3 shift/round; latency exactly 3 cycles with i_ready held high.
REQ-015 SHALL compute advance = !o_valid_S3 || i_ready; all stages move together on advance, hold otherwise; o_ready = advance.
REQ-016 SHALL accept input only when i_valid && o_ready; bubbles (valid=0) propagate; throughput 1/cycle.
REQ-017 SHALL hold o_fp_data, o_overflow, o_inexact stable while o_valid && !i_ready.
REQ-018 S1 SHALL take sign = i_acc[WWIDTH-1], mag = |i_acc| as WWIDTH-bit unsigned (-2^78 yields 2^78, no wrap).
REQ-019 S2 SHALL find leading-one index p of mag; unbiased exponent E = p - FWIDTH.
REQ-020 S3, mag = 0: output {sign=0, 0x0000}; zero is always +0; inexact=0.
REQ-021 S3, E+BIAS >= 1: mantissa = 10 bits below leading one, guard = next bit, sticky = OR of rest.
REQ-022 S3, E+BIAS <= 0: subnormal, exponent field 0, mantissa = mag bits [FWIDTH-15 : FWIDTH-24], guard/sticky below.
REQ-023 SHALL round to nearest, ties to even; mantissa carry-out increments exponent (subnormal 0x3FF+1 becomes 0x0400).
REQ-024 SHALL saturate to signed infinity (exp 31, mantissa 0) with o_overflow=1 when E > 15 or rounding reaches exp 31.
REQ-025 o_inexact SHALL be guard|sticky, also 1 on overflow.
REQ-026 SHALL never produce NaN.

Reset
REQ-027 rst_n low SHALL asynchronously clear all stage valids, o_valid=0, o_fp_data=0, o_overflow=0, o_inexact=0.
REQ-028 Reset mid-operation SHALL discard all in-flight data; first output after release is from the first input accepted after release.
REQ-029 o_ready SHALL be 1 during and immediately after reset.

Structure
REQ-030 WWIDTH, FWIDTH, EWIDTH, MWIDTH, BIAS, FP16 +INF/-INF constants SHALL live in shared package kulisch_pkg, also used by kulisch_acc_fp16.
REQ-031 Leading-one detection SHALL be sub-module kulisch_lzc (WWIDTH-bit in, 7-bit position + zero flag out, combinational).
REQ-032 Datapath regs SHALL have no reset; only valid and output regs reset.

Verification
REQ-033 i_acc = 1<<48 -> 0x3C00 after 3 cycles; i_acc = -(1<<48) -> 0xBC00; i_acc = 0 -> 0x0000, inexact 0.
REQ-034 i_acc = 1<<24 -> 0x0001; 3<<23 -> 0x0002 inexact; 1<<23 -> 0x0000 inexact (tie to even); 0x3FF<<24 + 1<<23 -> 0x0400.
REQ-035 i_acc = 65504<<48 -> 0x7BFF overflow 0; 65520<<48 -> 0x7C00 overflow 1; -(1<<78) -> 0xFC00 overflow 1.
REQ-036 Stream 8 back-to-back values, i_ready low cycles 4-5 -> o_ready low those cycles, output held, all 8 results in order, none lost or duplicated.
REQ-037 Assert rst_n low with 3 values in flight -> o_valid 0 immediately; after release, only new inputs emerge, latency 3.
